// File: rtl/car_dash_pkg.sv
// Shared move/game codes and defaults for the car dash pipeline.
// Also carries the BCD magnitude compare used by the high-score path.
package car_dash_pkg;

  localparam int unsigned NUM_LANES_DEF  = 6;
  localparam int unsigned TICK_COUNT_DEF = 50000000;

  typedef enum logic [1:0] {
    MOVE_NONE  = 2'b00,
    MOVE_RIGHT = 2'b01,
    MOVE_LEFT  = 2'b10,
    MOVE_HIT   = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } game_st_e;

  // Packed BCD a > b, most-significant digit decides first.
  function automatic logic bcd_gt(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic gt;
    logic eq;
    gt = 1'b0;
    eq = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (eq && (a[i*4+:4] > b[i*4+:4])) gt = 1'b1;
      if (a[i*4+:4] != b[i*4+:4]) eq = 1'b0;
    end
    return gt;
  endfunction

endpackage

// File: rtl/car_state_tracker_if.sv
// Tracker bus: tick/move inputs in, car/game status out.
// hiScore exists only when HIGH_SCORE_EN is defined.
interface car_state_tracker_if;

  logic [31:0] clkCnt;
  logic        start;
  logic [1:0]  moveResult;
  logic [5:0]  position;
  logic [5:0]  carRow;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [1:0]  gameState;
  logic        hitFlash;
`ifdef HIGH_SCORE_EN
  logic [15:0] hiScore;
`endif

  modport master (
    output clkCnt,
    output start,
    output moveResult,
    input  position,
    input  carRow,
    input  lives,
    input  score,
    input  gameState,
    input  hitFlash
`ifdef HIGH_SCORE_EN
    , input hiScore
`endif
  );

  modport slave (
    input  clkCnt,
    input  start,
    input  moveResult,
    output position,
    output carRow,
    output lives,
    output score,
    output gameState,
    output hitFlash
`ifdef HIGH_SCORE_EN
    , output hiScore
`endif
  );

endinterface

// File: rtl/car_state_tracker_bcd_score_counter.sv
// 4-digit packed BCD counter: clear, load, increment, sticks at 9999.
// Clear beats load beats increment.
module bcd_score_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  input  logic        ld,
  input  logic [15:0] ld_val,
  output logic [15:0] q
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        carry;

  // Next count with digit-to-digit carry ripple.
  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b1;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (inc && (cnt_q != 16'h9999)) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (cnt_q[i*4+:4] == 4'd9) begin
            cnt_d[i*4+:4] = 4'd0;
          end else begin
            cnt_d[i*4+:4] = cnt_q[i*4+:4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/car_state_tracker.sv
// Car lane position, lives, BCD score and game FSM after the move stage.
// Define HIGH_SCORE_EN to add the persistent hiScore output.
module car_state_tracker
  import car_dash_pkg::*;
#(
  parameter int unsigned TICK_COUNT  = TICK_COUNT_DEF,
  parameter int unsigned NUM_LANES   = NUM_LANES_DEF,
  parameter int unsigned START_POS   = 2,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned FLASH_TICKS = 2
) (
  input logic                clk,
  input logic                rst,
  car_state_tracker_if.slave bus
);

  localparam logic [31:0] SMP_CNT = 32'(TICK_COUNT + 1);
  localparam logic [5:0]  MAX_POS = 6'(NUM_LANES - 1);
  localparam logic [5:0]  ST_POS  = 6'(START_POS);
  localparam logic [2:0]  LIVES_V = 3'(LIVES);
  localparam logic [3:0]  FLASH_V = 4'(FLASH_TICKS);

  game_st_e    state_q, state_d;
  logic [5:0]  pos_q, pos_d;
  logic [2:0]  lives_q, lives_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic        flash_q, flash_d;
  logic        start_q;
  logic        sample_en;
  logic        start_rise;
  logic        score_clr;
  logic        score_inc;
  logic [15:0] score;

  assign sample_en  = (bus.clkCnt == SMP_CNT);
  assign start_rise = bus.start & ~start_q;

  // Game FSM plus position, lives and flash next-state.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    lives_d   = lives_q;
    fcnt_d    = fcnt_q;
    flash_d   = flash_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d   = ST_RUN;
          pos_d     = ST_POS;
          lives_d   = LIVES_V;
          fcnt_d    = '0;
          flash_d   = 1'b0;
          score_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (sample_en) begin
          score_inc = 1'b1;
          if (fcnt_q != '0) fcnt_d = fcnt_q - 4'd1;
          flash_d = (fcnt_d != '0);
          case (move_e'(bus.moveResult))
            MOVE_LEFT: begin
              if (pos_q < MAX_POS) pos_d = pos_q + 6'd1;
            end
            MOVE_RIGHT: begin
              if (pos_q != '0) pos_d = pos_q - 6'd1;
            end
            MOVE_HIT: begin
              fcnt_d  = FLASH_V;
              flash_d = 1'b1;
              if (lives_q <= 3'd1) begin
                lives_d   = '0;
                state_d   = ST_OVER;
                score_inc = 1'b0;
              end else begin
                lives_d = lives_q - 3'd1;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; start is edge-detected every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_q   <= ST_POS;
      lives_q <= LIVES_V;
      fcnt_q  <= '0;
      flash_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      lives_q <= lives_d;
      fcnt_q  <= fcnt_d;
      flash_q <= flash_d;
      start_q <= bus.start;
    end
  end

  bcd_score_counter u_score (
    .clk    (clk),
    .rst    (rst),
    .clr    (score_clr),
    .inc    (score_inc),
    .ld     (1'b0),
    .ld_val (16'h0000),
    .q      (score)
  );

`ifdef HIGH_SCORE_EN
  logic        hi_ld;
  logic [15:0] hi_score;

  assign hi_ld = (state_q == ST_RUN) && (state_d == ST_OVER)
              && bcd_gt(score, hi_score);

  bcd_score_counter u_hi (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .inc    (1'b0),
    .ld     (hi_ld),
    .ld_val (score),
    .q      (hi_score)
  );

  assign bus.hiScore = hi_score;
`endif

  assign bus.position  = pos_q;
  assign bus.carRow    = 6'b000001 << pos_q;
  assign bus.lives     = lives_q;
  assign bus.score     = score;
  assign bus.gameState = state_q;
  assign bus.hitFlash  = flash_q;

endmodule

// File: tb/tb_car_state_tracker.sv
// Scoreboard bench for car_state_tracker with directed move vectors.
// Build with HIGH_SCORE_EN defined to also check hiScore.
module tb_car_state_tracker;

  localparam int TICK = 10;
  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] NO = 2'b00;
  localparam logic [1:0] RT = 2'b01;
  localparam logic [1:0] LF = 2'b10;
  localparam logic [1:0] HT = 2'b11;

  typedef struct {
    logic [5:0]  pos;
    logic [5:0]  row;
    logic [2:0]  lives;
    logic [15:0] score;
    logic [1:0]  st;
    logic        fl;
    logic [15:0] hi;
  } exp_t;

  logic clk;
  logic rst;
  logic obs;
  logic start_prev;
  logic last_s;
  logic [15:0] ehi;
  int errors;
  int checks;
  exp_t q[$];
  exp_t me;
  exp_t dummy;

  car_state_tracker_if bus ();

  car_state_tracker #(
    .TICK_COUNT (TICK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output is presented after reset, a sample tick or a start rise.
  always @(posedge clk) begin
    obs <= rst || (bus.clkCnt == 32'(TICK + 1))
        || (bus.start && !start_prev);
    start_prev <= rst ? 1'b0 : bus.start;
  end

  always @(negedge clk) begin
    if (obs === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL empty: output seen, no expectation queued");
      end else begin
        logic ok;
        me = q.pop_front();
        ok = (bus.position === me.pos) && (bus.carRow === me.row)
          && (bus.lives === me.lives) && (bus.score === me.score)
          && (bus.gameState === me.st) && (bus.hitFlash === me.fl);
`ifdef HIGH_SCORE_EN
        ok = ok && (bus.hiScore === me.hi);
`endif
        if (!ok) begin
          errors++;
          $display("FAIL vec%0d: got pos=%0d row=%b lv=%0d sc=%h st=%b fl=%b want pos=%0d row=%b lv=%0d sc=%h st=%b fl=%b hi=%h",
                   checks, bus.position, bus.carRow, bus.lives,
                   bus.score, bus.gameState, bus.hitFlash,
                   me.pos, me.row, me.lives, me.score, me.st, me.fl,
                   me.hi);
        end
      end
    end
  end

  function automatic exp_t E(
    input int p, input int l, input logic [15:0] sc,
    input logic [1:0] st, input logic fl
  );
    exp_t e;
    e.pos   = 6'(p);
    e.row   = 6'b000001 << p;
    e.lives = 3'(l);
    e.score = sc;
    e.st    = st;
    e.fl    = fl;
    e.hi    = ehi;
    return e;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int n;
    n = v;
    for (int i = 0; i < 4; i++) begin
      b[i*4+:4] = 4'(n % 10);
      n = n / 10;
    end
    return b;
  endfunction

  task automatic cyc(
    input logic r, input logic s, input logic smp,
    input logic [1:0] mv, input exp_t e
  );
    @(negedge clk);
    rst            = r;
    bus.start      = s;
    bus.clkCnt     = smp ? 32'(TICK + 1) : 32'd3;
    bus.moveResult = mv;
    if (r || smp || (s && !last_s)) q.push_back(e);
    last_s = r ? 1'b0 : s;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ehi = 16'h0000;
    last_s = 1'b0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.clkCnt = 32'd0;
    bus.moveResult = NO;
    dummy = E(0, 0, 16'h0, I, 0);

    cyc(1, 0, 0, NO, E(2, 3, 16'h0000, I, 0));
    cyc(0, 0, 0, NO, dummy);
    cyc(0, 0, 1, LF, E(2, 3, 16'h0000, I, 0));
    cyc(0, 1, 0, NO, E(2, 3, 16'h0000, R, 0));
    cyc(0, 0, 0, NO, dummy);

    cyc(0, 0, 1, LF, E(3, 3, 16'h0001, R, 0));
    cyc(0, 0, 1, LF, E(4, 3, 16'h0002, R, 0));
    cyc(0, 0, 1, LF, E(5, 3, 16'h0003, R, 0));
    cyc(0, 0, 1, LF, E(5, 3, 16'h0004, R, 0));

    cyc(0, 0, 1, RT, E(4, 3, 16'h0005, R, 0));
    cyc(0, 0, 1, RT, E(3, 3, 16'h0006, R, 0));
    cyc(0, 0, 1, RT, E(2, 3, 16'h0007, R, 0));
    cyc(0, 0, 1, RT, E(1, 3, 16'h0008, R, 0));
    cyc(0, 0, 1, RT, E(0, 3, 16'h0009, R, 0));
    cyc(0, 0, 1, RT, E(0, 3, 16'h0010, R, 0));

    cyc(0, 0, 1, HT, E(0, 2, 16'h0011, R, 1));
    cyc(0, 0, 0, NO, dummy);
    cyc(0, 0, 1, NO, E(0, 2, 16'h0012, R, 1));
    cyc(0, 0, 1, NO, E(0, 2, 16'h0013, R, 0));
    cyc(0, 0, 1, NO, E(0, 2, 16'h0014, R, 0));

    cyc(0, 0, 1, HT, E(0, 1, 16'h0015, R, 1));
    ehi = 16'h0015;
    cyc(0, 0, 1, HT, E(0, 0, 16'h0015, O, 1));
    cyc(0, 0, 1, LF, E(0, 0, 16'h0015, O, 1));

    cyc(0, 1, 1, HT, E(2, 3, 16'h0000, R, 0));
    cyc(0, 0, 0, NO, dummy);
    cyc(0, 0, 1, HT, E(2, 2, 16'h0001, R, 1));
    cyc(0, 0, 1, HT, E(2, 1, 16'h0002, R, 1));
    cyc(0, 0, 1, HT, E(2, 0, 16'h0002, O, 1));

    cyc(0, 1, 0, NO, E(2, 3, 16'h0000, R, 0));
    cyc(0, 0, 0, NO, dummy);
    cyc(0, 0, 1, LF, E(3, 3, 16'h0001, R, 0));
    cyc(0, 1, 1, NO, E(3, 3, 16'h0002, R, 0));
    cyc(0, 0, 0, NO, dummy);

    for (int i = 3; i <= 10001; i++) begin
      cyc(0, 0, 1, NO,
          E(3, 3, to_bcd(i > 9999 ? 9999 : i), R, 0));
    end

    cyc(0, 0, 1, HT, E(3, 2, 16'h9999, R, 1));
    cyc(0, 0, 1, HT, E(3, 1, 16'h9999, R, 1));
    ehi = 16'h9999;
    cyc(0, 0, 1, HT, E(3, 0, 16'h9999, O, 1));
    cyc(0, 1, 0, NO, E(2, 3, 16'h0000, R, 0));
    cyc(0, 0, 0, NO, dummy);
    cyc(0, 0, 1, LF, E(3, 3, 16'h0001, R, 0));

    ehi = 16'h0000;
    cyc(1, 0, 0, NO, E(2, 3, 16'h0000, I, 0));
    cyc(0, 0, 0, NO, dummy);
    cyc(0, 0, 1, RT, E(2, 3, 16'h0000, I, 0));

    repeat (4) cyc(0, 0, 0, NO, dummy);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0",
               q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
